// File: rtl/csm_pkg.sv
// csm_pkg: shared types and defaults for the shared-memory arbiter.
// Imported by csm_lock_timer and csm_arbiter.
package csm_pkg;

  localparam int CSM_LOCK_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_A,
    GRANT_B,
    LOCK_A,
    LOCK_B
  } csm_arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    DENIED = 2'b01,
    TIMEOUT = 2'b10,
    BADREL = 2'b11
  } csm_err_t;

  // A bad release outranks a timeout, which outranks a denial.
  function automatic csm_err_t err_pick(
    input logic badrel,
    input logic tmo,
    input logic deny
  );
    if (badrel) return BADREL;
    if (tmo) return TIMEOUT;
    if (deny) return DENIED;
    return NONE;
  endfunction

endpackage

// File: rtl/csm_lock_timer.sv
// csm_lock_timer: counts idle cycles of a locked owner and flags
// the last cycle before the lock must be forced open.
module csm_lock_timer
  import csm_pkg::*;
#(
  parameter int LOCK_TIMEOUT = CSM_LOCK_TIMEOUT,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL =
    CNT_W'(LOCK_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/csm_arbiter.sv
// csm_arbiter: two-port shared-memory arbiter with round-robin
// arbitration, optional multi-transaction lock and idle timeout.
module csm_arbiter
  import csm_pkg::*;
#(
  parameter int LOCK_TIMEOUT = CSM_LOCK_TIMEOUT,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A_req,
  input  logic       B_req,
  input  logic       A_hold,
  input  logic       B_hold,
  input  logic       A_release,
  input  logic       B_release,
  output logic       A_grant,
  output logic       B_grant,
  output logic [1:0] A_err,
  output logic [1:0] B_err,
  output logic       mem_sel,
  output logic       mem_enable,
  output logic       lock_active
);

  csm_arb_state_t state_q, state_d;

  // last_q = 1 means B was served last, so A wins a tie.
  logic last_q, last_d;
  logic a_tmo, b_tmo;
  logic a_own, b_own;
  logic locked, own_req;
  logic t_inc, t_clr, tc;
  logic a_gnt_d, b_gnt_d;
  logic a_badrel, b_badrel;
  logic a_deny, b_deny;

  assign a_own = (state_q == GRANT_A) ||
                 (state_q == LOCK_A);
  assign b_own = (state_q == GRANT_B) ||
                 (state_q == LOCK_B);
  assign locked = (state_q == LOCK_A) ||
                  (state_q == LOCK_B);
  assign own_req = (state_q == LOCK_A) ? A_req : B_req;

  assign t_inc = locked && !own_req &&
                 (state_d == state_q);
  assign t_clr = !t_inc;

  csm_lock_timer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(t_clr),
    .inc(t_inc),
    .tc(tc)
  );

  always_comb begin
    state_d = state_q;
    last_d = last_q;
    a_tmo = 1'b0;
    b_tmo = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (A_req && (!B_req || last_q)) begin
          state_d = A_hold ? LOCK_A : GRANT_A;
        end else if (B_req) begin
          state_d = B_hold ? LOCK_B : GRANT_B;
        end
      end
      GRANT_A: begin
        if (!A_req) begin
          state_d = IDLE;
          last_d = 1'b0;
        end else if (A_hold) begin
          state_d = LOCK_A;
        end
      end
      GRANT_B: begin
        if (!B_req) begin
          state_d = IDLE;
          last_d = 1'b1;
        end else if (B_hold) begin
          state_d = LOCK_B;
        end
      end
      LOCK_A: begin
        if (A_release) begin
          state_d = IDLE;
          last_d = 1'b0;
        end else if (!A_req && tc) begin
          state_d = IDLE;
          last_d = 1'b0;
          a_tmo = 1'b1;
        end
      end
      LOCK_B: begin
        if (B_release) begin
          state_d = IDLE;
          last_d = 1'b1;
        end else if (!B_req && tc) begin
          state_d = IDLE;
          last_d = 1'b1;
          b_tmo = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_gnt_d = (state_d == GRANT_A) ||
                   (state_d == LOCK_A);
  assign b_gnt_d = (state_d == GRANT_B) ||
                   (state_d == LOCK_B);

  assign a_badrel = A_release && !a_own;
  assign b_badrel = B_release && !b_own;
  assign a_deny = A_req && (state_q == LOCK_B);
  assign b_deny = B_req && (state_q == LOCK_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      A_grant     <= 1'b0;
      B_grant     <= 1'b0;
      A_err       <= NONE;
      B_err       <= NONE;
      mem_sel     <= 1'b0;
      mem_enable  <= 1'b0;
      lock_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      A_grant     <= a_gnt_d;
      B_grant     <= b_gnt_d;
      A_err       <= err_pick(a_badrel, a_tmo, a_deny);
      B_err       <= err_pick(b_badrel, b_tmo, b_deny);
      mem_enable  <= a_gnt_d || b_gnt_d;
      lock_active <= (state_d == LOCK_A) ||
                     (state_d == LOCK_B);
      if (a_gnt_d) begin
        mem_sel <= 1'b0;
      end else if (b_gnt_d) begin
        mem_sel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csm_arbiter.sv
// tb_csm_arbiter: directed and random stimulus checked every cycle
// against an owner/lock reference model of the arbiter.
module tb_csm_arbiter;

  localparam int LT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req [2];
  logic hold [2];
  logic rel [2];
  logic A_grant, B_grant;
  logic [1:0] A_err, B_err;
  logic mem_sel, mem_enable, lock_active;

  int n_assert = 0;
  int n_fail = 0;

  // reference model: owner -1 none, 0 A, 1 B
  int owner, last, idle;
  bit locked;
  logic e_gnt [2];
  logic [1:0] e_err [2];
  logic e_sel, e_en, e_lock;

  always #5 clk = ~clk;

  csm_arbiter #(
    .LOCK_TIMEOUT(LT),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A_req(req[0]),
    .B_req(req[1]),
    .A_hold(hold[0]),
    .B_hold(hold[1]),
    .A_release(rel[0]),
    .B_release(rel[1]),
    .A_grant(A_grant),
    .B_grant(B_grant),
    .A_err(A_err),
    .B_err(B_err),
    .mem_sel(mem_sel),
    .mem_enable(mem_enable),
    .lock_active(lock_active)
  );

  function automatic void publish();
    for (int p = 0; p < 2; p++) e_gnt[p] = (owner == p);
    e_en = (owner >= 0);
    e_lock = (owner >= 0) && locked;
    if (owner >= 0) e_sel = owner[0];
  endfunction

  function automatic void model_reset();
    owner = -1;
    last = 1;
    idle = 0;
    locked = 0;
    e_err[0] = 2'b00;
    e_err[1] = 2'b00;
    e_sel = 1'b0;
    publish();
  endfunction

  function automatic void free_owner(input int o);
    last = o;
    owner = -1;
    locked = 0;
    idle = 0;
  endfunction

  function automatic void model_step();
    int w;
    int o;
    e_err[0] = 2'b00;
    e_err[1] = 2'b00;
    for (int p = 0; p < 2; p++)
      if (rel[p] && owner != p) e_err[p] = 2'b11;
    if (owner < 0) begin
      w = -1;
      if (req[0] && req[1]) w = 1 - last;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
      if (w >= 0) begin
        owner = w;
        locked = hold[w];
        idle = 0;
      end
    end else if (!locked) begin
      o = owner;
      if (!req[o]) free_owner(o);
      else if (hold[o]) begin
        locked = 1;
        idle = 0;
      end
    end else begin
      o = owner;
      if (req[1-o] && e_err[1-o] == 2'b00)
        e_err[1-o] = 2'b01;
      if (rel[o]) free_owner(o);
      else if (req[o]) idle = 0;
      else begin
        idle++;
        if (idle == LT) begin
          free_owner(o);
          e_err[o] = 2'b10;
        end
      end
    end
    publish();
  endfunction

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("A_grant", {1'b0, A_grant}, {1'b0, e_gnt[0]});
    chk("B_grant", {1'b0, B_grant}, {1'b0, e_gnt[1]});
    chk("A_err", A_err, e_err[0]);
    chk("B_err", B_err, e_err[1]);
    chk("mem_sel", {1'b0, mem_sel}, {1'b0, e_sel});
    chk("mem_enable", {1'b0, mem_enable}, {1'b0, e_en});
    chk("lock_active", {1'b0, lock_active}, {1'b0, e_lock});
    chk("one_grant", {1'b0, A_grant & B_grant}, 2'b00);
  endtask

  task automatic step(input bit ar, input bit ah, input bit al,
                      input bit br, input bit bh, input bit bl);
    req[0] = ar;
    hold[0] = ah;
    rel[0] = al;
    req[1] = br;
    hold[1] = bh;
    rel[1] = bl;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_n(2);
    chk("rst_en", {1'b0, mem_enable}, 2'b00);
    chk("rst_sel", {1'b0, mem_sel}, 2'b00);
    reset = 1'b0;

    // single requester, three cycles
    step(1, 0, 0, 0, 0, 0);
    chk("r030_grant", {1'b0, A_grant}, 2'b01);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("r030_drop", {1'b0, mem_enable}, 2'b00);

    // tie after reset, then round-robin
    reset = 1'b1;
    idle_n(1);
    reset = 1'b0;
    step(1, 0, 0, 1, 0, 0);
    chk("r031_a_first", {1'b0, A_grant}, 2'b01);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("r031_b_next", {1'b0, B_grant}, 2'b01);
    step(1, 0, 0, 0, 0, 0);
    idle_n(1);

    // B locks, A denied, then handoff
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 0, 0);
      chk("r032_deny", A_err, 2'b01);
    end
    chk("r032_lock", {1'b0, lock_active}, 2'b01);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("r032_handoff", {1'b0, A_grant}, 2'b01);
    idle_n(2);

    // A locks then idles into timeout
    step(1, 1, 0, 0, 0, 0);
    idle_n(LT);
    chk("r033_tmo", A_err, 2'b10);
    idle_n(1);
    chk("r033_pulse", A_err, 2'b00);

    // release and timeout in the same cycle
    step(1, 1, 0, 0, 0, 0);
    idle_n(LT - 1);
    step(0, 0, 1, 0, 0, 0);
    chk("r022_no_tmo", A_err, 2'b00);

    // bad release while A owns a plain grant
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("r034_badrel", B_err, 2'b11);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // grant to lock without a gap
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    idle_n(1);

    // reset in the middle of a lock
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 1, 0, 0);
    chk("r035_grant", {1'b0, A_grant}, 2'b00);
    chk("r035_err", A_err | B_err, 2'b00);
    reset = 1'b0;
    idle_n(1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0);
    end
    reset = 1'b0;
    idle_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
